// File: rtl/context_switch_scheduler.sv
// Context switch sequencer: drives the registered global_stage and inserts WRITE plus a LOAD window
// per switch. It also owns the active-context pointer and the ctx_min/ctx_max window.
module context_switch_scheduler #(
  parameter int NUM_CONTEXTS = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int STAGE_WIDTH = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE = '0,
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM = {STAGE_WIDTH{1'b1}},
  localparam int CTX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [STAGE_WIDTH-1:0] stage_in,
  input  logic                   start,
  input  logic                   switch_req,
  input  logic                   store_en,
  input  logic                   phase_peel,
  input  logic                   block_done,
  output logic [STAGE_WIDTH-1:0] global_stage,
  output logic                   do_not_store,
  output logic                   switch_ack,
  output logic                   busy,
  output logic [CTX_W-1:0]       ctx_id,
  output logic [CTX_W-1:0]       ctx_min,
  output logic [CTX_W-1:0]       ctx_max
);

  // Handshake: switch_req is a level held until switch_ack. The ack cycle consumes the request,
  // so a switch_req still high while switch_ack=1 does not start another switch.
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_WRITE, S_LOAD} state_t;

  localparam int HALF = NUM_CONTEXTS / 2;
  localparam logic [CTX_W-1:0] HALF_C    = CTX_W'(HALF);
  localparam logic [CTX_W-1:0] TOP_C     = CTX_W'(NUM_CONTEXTS - 1);
  localparam logic [CTX_W-1:0] LOW_TOP_C = (HALF > 0) ? CTX_W'(HALF - 1) : '0;
  localparam logic [2:0]       LOAD_INIT = 3'(LOAD_LATENCY - 1);
  localparam bit               MULTI     = (NUM_CONTEXTS > 1);

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   store_l_q, store_l_d;
  logic [STAGE_WIDTH-1:0] gs_q, gs_d;
  logic                   dns_q, dns_d;
  logic                   ack_q, ack_d;
  logic [CTX_W-1:0]       ctx_q, ctx_d;
  logic [CTX_W-1:0]       min_q, min_d;
  logic [CTX_W-1:0]       max_q, max_d;
  logic                   first_q, first_d;
  logic                   full_q, full_d;
  logic [CTX_W-1:0]       ctx_next;
  logic                   win_hit;
  logic                   in_low;

  // A context outside the current window restarts at ctx_min.
  always_comb begin
    ctx_next = '0;
    if (NUM_CONTEXTS == 2) begin
      ctx_next = ~ctx_q;
    end else if (NUM_CONTEXTS > 2) begin
      ctx_next = (ctx_q >= min_q && ctx_q < max_q) ? ctx_q + 1'b1 : min_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    store_l_d = store_l_q;
    gs_d      = STAGE_IDLE;
    dns_d     = 1'b0;
    ack_d     = 1'b0;
    ctx_d     = ctx_q;
    min_d     = min_q;
    max_d     = max_q;
    first_d   = first_q;
    full_d    = full_q;
    win_hit   = (ctx_q == '0) || (ctx_q == HALF_C);
    in_low    = (ctx_q < HALF_C);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACTIVE;
          ctx_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (block_done && win_hit) begin
          if (phase_peel) begin
            min_d = in_low ? '0 : HALF_C;
            max_d = in_low ? LOW_TOP_C : TOP_C;
          end else if (first_q) begin
            min_d   = HALF_C;
            max_d   = TOP_C;
            first_d = 1'b0;
          end else if (!full_q) begin
            min_d  = '0;
            max_d  = TOP_C;
            full_d = 1'b1;
          end else begin
            min_d  = in_low ? HALF_C : '0;
            max_d  = in_low ? TOP_C : LOW_TOP_C;
            full_d = 1'b0;
          end
        end
        if (switch_req && !ack_q) begin
          state_d   = S_WRITE;
          store_l_d = store_en && MULTI;
          gs_d      = STAGE_WRITE_TO_MEM;
          dns_d     = !(store_en && MULTI);
        end else begin
          gs_d = stage_in;
        end
      end
      S_WRITE: begin
        state_d = S_LOAD;
        cnt_d   = LOAD_INIT;
        if (store_l_q) ctx_d = ctx_next;
      end
      S_LOAD: begin
        if (cnt_q == 3'd0) begin
          state_d = S_ACTIVE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      store_l_q <= 1'b0;
      gs_q      <= STAGE_IDLE;
      dns_q     <= 1'b0;
      ack_q     <= 1'b0;
      ctx_q     <= '0;
      min_q     <= '0;
      max_q     <= LOW_TOP_C;
      first_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      store_l_q <= store_l_d;
      gs_q      <= gs_d;
      dns_q     <= dns_d;
      ack_q     <= ack_d;
      ctx_q     <= ctx_d;
      min_q     <= min_d;
      max_q     <= max_d;
      first_q   <= first_d;
      full_q    <= full_d;
    end
  end

  assign global_stage = gs_q;
  assign do_not_store = dns_q;
  assign switch_ack   = ack_q;
  assign busy         = (state_q == S_WRITE) || (state_q == S_LOAD);
  assign ctx_id       = ctx_q;
  assign ctx_min      = min_q;
  assign ctx_max      = max_q;

endmodule

// File: tb/tb_context_switch_scheduler.sv
// Bench for context_switch_scheduler: three configurations share one stimulus stream and are
// checked every cycle against a timeline model, plus directed literal expectations.
module tb_context_switch_scheduler;

  localparam int NT [3] = '{4, 4, 2};
  localparam int LT [3] = '{1, 3, 2};
  localparam int ST_IDLE = 0;
  localparam int ST_WRITE = 7;

  logic       clk;
  logic       reset, start, switch_req, store_en, phase_peel, block_done;
  logic [2:0] stage_in;
  logic [2:0] gs_a [3];
  logic       dns_a [3], ack_a [3], busy_a [3];
  logic [1:0] ctx_a [3], min_a [3], max_a [3];

  int n_checks = 0;
  int n_fail = 0;
  bit model_on = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (NT[g] > 1) ? $clog2(NT[g]) : 1;
    logic [CW-1:0] ctx_w, min_w, max_w;
    context_switch_scheduler #(.NUM_CONTEXTS(NT[g]), .LOAD_LATENCY(LT[g])) u_dut (
      .clk(clk), .reset(reset), .stage_in(stage_in), .start(start),
      .switch_req(switch_req), .store_en(store_en), .phase_peel(phase_peel),
      .block_done(block_done), .global_stage(gs_a[g]), .do_not_store(dns_a[g]),
      .switch_ack(ack_a[g]), .busy(busy_a[g]), .ctx_id(ctx_w), .ctx_min(min_w),
      .ctx_max(max_w)
    );
    assign ctx_a[g] = 2'(ctx_w);
    assign min_a[g] = 2'(min_w);
    assign max_a[g] = 2'(max_w);
  end

  // ---------------- model ----------------
  // mode 0 idle, 1 running, 2 switching; since = cycles elapsed since the switch was accepted.
  int m_mode [3], m_since [3], m_store [3], m_ctx [3], m_lo [3], m_hi [3];
  int m_first [3], m_full [3], e_gs [3], e_dns [3], e_ack [3];

  function automatic void win_update(int k);
    int n, half;
    n = NT[k];
    half = n / 2;
    if (phase_peel) begin
      if (m_ctx[k] < half) begin m_lo[k] = 0; m_hi[k] = half - 1; end
      else begin m_lo[k] = half; m_hi[k] = n - 1; end
    end else if (m_first[k] != 0) begin
      m_lo[k] = half; m_hi[k] = n - 1; m_first[k] = 0;
    end else if (m_full[k] == 0) begin
      m_lo[k] = 0; m_hi[k] = n - 1; m_full[k] = 1;
    end else begin
      if (m_ctx[k] < half) begin m_lo[k] = half; m_hi[k] = n - 1; end
      else begin m_lo[k] = 0; m_hi[k] = half - 1; end
      m_full[k] = 0;
    end
  endfunction

  function automatic void advance(int k);
    int nxt;
    if (NT[k] == 2) m_ctx[k] = 1 - m_ctx[k];
    else if (NT[k] > 2) begin
      nxt = m_lo[k];
      for (int i = m_lo[k]; i < m_hi[k]; i++) if (i == m_ctx[k]) nxt = i + 1;
      m_ctx[k] = nxt;
    end
  endfunction

  function automatic void step(int k);
    int half;
    bit ack_now;
    half = NT[k] / 2;
    ack_now = (e_ack[k] != 0);
    e_gs[k] = ST_IDLE; e_dns[k] = 0; e_ack[k] = 0;
    if (!reset) begin
      m_mode[k] = 0; m_ctx[k] = 0; m_lo[k] = 0; m_hi[k] = (half > 0) ? half - 1 : 0;
      m_first[k] = 1; m_full[k] = 0;
      return;
    end
    case (m_mode[k])
      0: if (start) begin m_mode[k] = 1; m_ctx[k] = 0; end
      1: begin
        if (block_done && (m_ctx[k] == 0 || m_ctx[k] == half)) win_update(k);
        if (switch_req && !ack_now) begin
          m_mode[k] = 2; m_since[k] = 1;
          m_store[k] = (store_en && NT[k] > 1) ? 1 : 0;
          e_gs[k] = ST_WRITE; e_dns[k] = 1 - m_store[k];
        end else begin
          e_gs[k] = int'(stage_in);
        end
      end
      default: begin
        if (m_since[k] == 1 && m_store[k] != 0) advance(k);
        m_since[k]++;
        if (m_since[k] == 2 + LT[k]) begin m_mode[k] = 1; e_ack[k] = 1; end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) step(k);
    model_on = 1;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        chk("global_stage", k, int'(gs_a[k]), e_gs[k]);
        chk("do_not_store", k, int'(dns_a[k]), e_dns[k]);
        chk("switch_ack", k, int'(ack_a[k]), e_ack[k]);
        chk("busy", k, int'(busy_a[k]), (m_mode[k] == 2) ? 1 : 0);
        chk("ctx_id", k, int'(ctx_a[k]), m_ctx[k]);
        chk("ctx_min", k, int'(min_a[k]), m_lo[k]);
        chk("ctx_max", k, int'(max_a[k]), m_hi[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic restart();
    reset = 0; switch_req = 0; block_done = 0; start = 0; phase_peel = 0;
    repeat (2) @(negedge clk);
    reset = 1; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
  endtask

  task automatic do_switch(input bit st, input int exp_ctx);
    switch_req = 1; store_en = st;
    @(negedge clk);
    chk("lit_write_stage", 0, int'(gs_a[0]), ST_WRITE);
    chk("lit_dns", 0, int'(dns_a[0]), st ? 0 : 1);
    @(negedge clk);
    chk("lit_load_noack", 0, int'(ack_a[0]), 0);
    @(negedge clk);
    chk("lit_ack", 0, int'(ack_a[0]), 1);
    chk("lit_ctx", 0, int'(ctx_a[0]), exp_ctx);
    switch_req = 0; store_en = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_done(input bit peel, input int lo, input int hi);
    block_done = 1; phase_peel = peel;
    @(negedge clk);
    block_done = 0; phase_peel = 0;
    chk("lit_win_min", 0, int'(min_a[0]), lo);
    chk("lit_win_max", 0, int'(max_a[0]), hi);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks;
    reset = 0; start = 0; switch_req = 0; store_en = 0;
    phase_peel = 0; block_done = 0; stage_in = 0;
    repeat (2) @(negedge clk);
    chk("lit_rst_stage", 0, int'(gs_a[0]), ST_IDLE);
    chk("lit_rst_max", 0, int'(max_a[0]), 1);
    chk("lit_rst_min", 0, int'(min_a[0]), 0);
    chk("lit_rst_busy", 0, int'(busy_a[0]), 0);
    reset = 1; start = 1;
    @(negedge clk);
    start = 0;
    chk("lit_start_ctx", 0, int'(ctx_a[0]), 0);
    stage_in = 3'd5;
    @(negedge clk);
    chk("lit_stage_pass", 0, int'(gs_a[0]), 5);
    stage_in = 3'd0;

    do_switch(1, 1);
    do_switch(1, 0);
    do_switch(0, 0);
    pulse_done(0, 2, 3);
    do_switch(1, 2);
    pulse_done(0, 0, 3);
    pulse_done(0, 0, 1);
    pulse_done(1, 2, 3);

    restart();
    for (int i = 0; i < 4; i++) begin
      do_switch(1, (i % 2 == 0) ? 1 : 0);
      chk("lit_n2_ctx", 2, int'(ctx_a[2]), (i % 2 == 0) ? 1 : 0);
    end
    acks = 0;
    switch_req = 1; store_en = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack_a[2]) begin acks++; switch_req = 0; end
    end
    switch_req = 0;
    chk("lit_n2_one_ack", 2, acks, 1);

    restart();
    switch_req = 1; store_en = 1;
    @(negedge clk);
    switch_req = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("lit_abort_busy", 1, int'(busy_a[1]), 0);
    chk("lit_abort_ctx", 1, int'(ctx_a[1]), 0);
    chk("lit_abort_stage", 1, int'(gs_a[1]), ST_IDLE);
    reset = 1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a[1]) acks++;
    end
    chk("lit_abort_noack", 1, acks, 0);

    restart();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) != 0);
      start      = ($urandom_range(0, 15) == 0);
      switch_req = ($urandom_range(0, 2) == 0);
      store_en   = ($urandom_range(0, 3) != 0);
      phase_peel = ($urandom_range(0, 3) == 0);
      block_done = ($urandom_range(0, 3) == 0);
      stage_in   = 3'($urandom_range(0, 7));
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
